// File: rtl/nco_pkg.sv
// Shared encodings for the NCO scheduler: config selects, FSM states, dither LFSR constants.
package nco_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    OUT  = 2'd3
  } state_e;

  localparam logic [1:0] CFG_FREQ = 2'd0;
  localparam logic [1:0] CFG_OFFS = 2'd1;
  localparam logic [1:0] CFG_CLR  = 2'd2;

  // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nco_scheduler_if.sv
// Channel-tagged sample stream from the scheduler to the FIFO writer.
interface nco_scheduler_if #(
  parameter int DATA_WIDTH = 12,
  parameter int CH_W       = 1
);
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic [CH_W-1:0]       m_ch;
  logic                  m_ready;

  modport master (output m_valid, output m_data, output m_ch, input m_ready);
  modport slave  (input m_valid, input m_data, input m_ch, output m_ready);
endinterface

// File: rtl/nco_phase_bank.sv
// Per-channel tuning word, phase offset and accumulator with config decode.
// rd_phase forwards a same-cycle accumulate on the read channel so a single-channel build stays in step.
module nco_phase_bank
  import nco_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int PHASE_WIDTH = 32,
  parameter int CH_W        = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_wr,
  input  logic [CH_W-1:0]        cfg_ch,
  input  logic [1:0]             cfg_sel,
  input  logic [PHASE_WIDTH-1:0] cfg_data,
  input  logic [CH_W-1:0]        rd_ch,
  input  logic                   acc_stb,
  input  logic [CH_W-1:0]        acc_ch,
  output logic [PHASE_WIDTH-1:0] rd_phase
);

  logic [PHASE_WIDTH-1:0] freq_q [NUM_CH];
  logic [PHASE_WIDTH-1:0] freq_d [NUM_CH];
  logic [PHASE_WIDTH-1:0] offs_q [NUM_CH];
  logic [PHASE_WIDTH-1:0] offs_d [NUM_CH];
  logic [PHASE_WIDTH-1:0] acc_q  [NUM_CH];
  logic [PHASE_WIDTH-1:0] acc_d  [NUM_CH];
  logic [PHASE_WIDTH-1:0] fwd;

  always_comb begin
    freq_d = freq_q;
    offs_d = offs_q;
    acc_d  = acc_q;
    if (acc_stb) acc_d[acc_ch] = acc_q[acc_ch] + freq_q[acc_ch];
    // Decoded after the accumulate so a clear on the same channel wins.
    if (cfg_wr && (int'(cfg_ch) < NUM_CH)) begin
      case (cfg_sel)
        CFG_FREQ: freq_d[cfg_ch] = cfg_data;
        CFG_OFFS: offs_d[cfg_ch] = cfg_data;
        CFG_CLR:  acc_d[cfg_ch]  = '0;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      freq_q <= '{default: '0};
      offs_q <= '{default: '0};
      acc_q  <= '{default: '0};
    end else begin
      freq_q <= freq_d;
      offs_q <= offs_d;
      acc_q  <= acc_d;
    end
  end

  assign fwd      = (acc_stb && (rd_ch == acc_ch)) ? freq_q[acc_ch] : '0;
  assign rd_phase = acc_q[rd_ch] + fwd + offs_q[rd_ch];

endmodule

// File: rtl/nco_scheduler.sv
// Round-robin scheduler sharing one 1-cycle-latency sine LUT across NUM_CH NCO channels.
// Optional phase dither before address truncation: define NCO_PHASE_DITHER_EN.
module nco_scheduler
  import nco_pkg::*;
#(
  parameter int  NUM_CH      = 2,
  parameter int  PHASE_WIDTH = 32,
  parameter int  ADDR_WIDTH  = 10,
  parameter int  DATA_WIDTH  = 12,
  localparam int CH_W        = ch_width(NUM_CH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   cfg_wr,
  input  logic [CH_W-1:0]        cfg_ch,
  input  logic [1:0]             cfg_sel,
  input  logic [PHASE_WIDTH-1:0] cfg_data,
  output logic [ADDR_WIDTH-1:0]  rom_addr,
  input  logic [DATA_WIDTH-1:0]  rom_dout,
  output logic                   busy,
  nco_scheduler_if.master        m_if
);

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  rom_addr_q, rom_addr_d;
  logic [DATA_WIDTH-1:0]  m_data_q, m_data_d;
  logic [CH_W-1:0]        m_ch_q, m_ch_d;
  logic                   m_valid_q, m_valid_d;
  logic [CH_W-1:0]        ch_ptr_q, ch_ptr_d;
  logic [CH_W-1:0]        ch_next;
  logic [CH_W-1:0]        rd_ch;
  logic                   acc_stb;
  logic [PHASE_WIDTH-1:0] rd_phase;
  logic [PHASE_WIDTH-1:0] phase_adj;
  logic [ADDR_WIDTH-1:0]  load_addr;

  nco_phase_bank #(
    .NUM_CH      (NUM_CH),
    .PHASE_WIDTH (PHASE_WIDTH),
    .CH_W        (CH_W)
  ) u_bank (
    .clk      (clk),
    .rst      (rst),
    .cfg_wr   (cfg_wr),
    .cfg_ch   (cfg_ch),
    .cfg_sel  (cfg_sel),
    .cfg_data (cfg_data),
    .rd_ch    (rd_ch),
    .acc_stb  (acc_stb),
    .acc_ch   (ch_ptr_q),
    .rd_phase (rd_phase)
  );

`ifdef NCO_PHASE_DITHER_EN
  localparam int DITH_W = ((PHASE_WIDTH - ADDR_WIDTH) > 16) ? 16 : (PHASE_WIDTH - ADDR_WIDTH);
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (acc_stb) lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign phase_adj = rd_phase + PHASE_WIDTH'(lfsr_q[DITH_W-1:0]);
`else
  assign phase_adj = rd_phase;
`endif

  assign load_addr = phase_adj[PHASE_WIDTH-1 -: ADDR_WIDTH];
  assign ch_next   = (ch_ptr_q == CH_W'(NUM_CH - 1)) ? '0 : ch_ptr_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    m_data_d   = m_data_q;
    m_ch_d     = m_ch_q;
    m_valid_d  = m_valid_q;
    ch_ptr_d   = ch_ptr_q;
    rd_ch      = ch_ptr_q;
    acc_stb    = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          rom_addr_d = load_addr;
          state_d    = ADDR;
        end
      end
      ADDR: state_d = DATA;
      DATA: begin
        m_data_d  = rom_dout;
        m_ch_d    = ch_ptr_q;
        m_valid_d = 1'b1;
        state_d   = OUT;
      end
      OUT: begin
        if (m_if.m_ready) begin
          m_valid_d = 1'b0;
          acc_stb   = 1'b1;
          ch_ptr_d  = ch_next;
          rd_ch     = ch_next;
          if (enable) begin
            rom_addr_d = load_addr;
            state_d    = ADDR;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rom_addr_q <= '0;
      m_data_q   <= '0;
      m_ch_q     <= '0;
      m_valid_q  <= 1'b0;
      ch_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      m_data_q   <= m_data_d;
      m_ch_q     <= m_ch_d;
      m_valid_q  <= m_valid_d;
      ch_ptr_q   <= ch_ptr_d;
    end
  end

  assign rom_addr     = rom_addr_q;
  assign busy         = (state_q != IDLE);
  assign m_if.m_valid = m_valid_q;
  assign m_if.m_data  = m_data_q;
  assign m_if.m_ch    = m_ch_q;

endmodule
